// File: rtl/w_pkg.sv
// Shared constants for the accelerator wrapper result path.
//  - default result word width, FIFO depth and frame length
//  - result-buffer FSM state encoding (2 bits)
//  - saturating increment helper for the 4-bit per-run word counter
package w_pkg;

  localparam int W_WIDTH_DEF = 16;
  localparam int W_DEPTH_DEF = 8;
  localparam int W_FRAME_DEF = 4;

  localparam int W_WCNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_CLOSE = 2'd2;

  function automatic logic [W_WCNT_W-1:0] sat_inc4(input logic [W_WCNT_W-1:0] v);
    if (v == {W_WCNT_W{1'b1}}) begin
      return v;
    end
    return v + W_WCNT_W'(1);
  endfunction

endpackage

// File: rtl/w_fifo_core.sv
// Circular first-word-fall-through FIFO used by the result buffer.
// Ports:
//  clk, rst_n     clock, async active-low reset
//  i_clr          synchronous flush of pointers and count (wins over wr/pop)
//  i_wr, i_din    write request and data; dropped when full unless a pop frees a slot
//  i_rd_ready     consumer accepts head word when o_valid is high
//  o_valid        FIFO not empty
//  o_data         head word, forced to zero while empty
//  o_count        stored words, 0..DEPTH
//  o_drop         a write request was refused this cycle (FIFO full, no pop)
module w_fifo_core #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_rd_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && i_rd_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take a word.
  assign w_push  = i_wr && (!w_full || w_pop);

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_drop  = i_wr && !w_push && !i_clr;

  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: a word is only ever read after it has been written,
  // and the head output is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

endmodule

// File: rtl/w_result_buffer.sv
// Result stage for the accelerator wrapper: buffers result words written during
// a wrapper run, drains them to the host over valid/ready, and tracks run
// boundaries from the wrapper idle level wDone.
// Ports:
//  clk, rst_n        clock, async active-low reset
//  clr               synchronous flush of FIFO, FSM, flags and frame counter
//  wr, din           wrapper result write strobe and word
//  wDone             wrapper idle level (1 = idle, 0 = run in progress)
//  out_valid/out_data/out_ready   host drain port (first-word fall-through)
//  space_ok          at least FRAME free entries, lets the issuer start a run
//  frame_done        one-cycle pulse when a run closes
//  frame_err         sticky: a run delivered != FRAME words, or a stray write
//  overflow          sticky: a write was dropped because the FIFO was full
//  frame_cnt         completed runs, wraps at 256
//
// State table
//  state    | meaning
//  ST_IDLE  | wrapper idle (wDone=1); any wr here is a stray write
//  ST_BUSY  | run in progress; every wr is counted, accepted or dropped
//  ST_CLOSE | one-cycle run close: pulse frame_done, bump frame_cnt, check count
module w_result_buffer
  import w_pkg::*;
#(
  parameter int WIDTH = W_WIDTH_DEF,
  parameter int DEPTH = W_DEPTH_DEF,
  parameter int FRAME = W_FRAME_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             wDone,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             space_ok,
  output logic             frame_done,
  output logic             frame_err,
  output logic             overflow,
  output logic [7:0]       frame_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SPACE_LIM = DEPTH - FRAME;
  localparam logic [W_WCNT_W-1:0] FRAME_WORDS = W_WCNT_W'(FRAME);

  logic [1:0]          r_state;
  logic [W_WCNT_W-1:0] r_word_cnt;
  logic                r_frame_err;
  logic                r_overflow;
  logic [7:0]          r_frame_cnt;

  logic [CW-1:0]       w_count;
  logic                w_drop;
  logic [W_WCNT_W-1:0] w_close_words;

  w_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (clr),
    .i_wr       (wr),
    .i_din      (din),
    .i_rd_ready (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_count    (w_count),
    .o_drop     (w_drop)
  );

  // space_ok follows the registered count, so it reflects a push/pop one cycle later.
  assign space_ok   = (w_count <= CW'(SPACE_LIM));
  assign frame_done = (r_state == ST_CLOSE);
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign frame_cnt  = r_frame_cnt;

  // A write landing in the close cycle still belongs to the run being checked.
  assign w_close_words = wr ? sat_inc4(r_word_cnt) : r_word_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else if (clr) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (wr) begin
            r_frame_err <= 1'b1;
          end
          if (!wDone) begin
            r_state    <= ST_BUSY;
            r_word_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (wr) begin
            r_word_cnt <= sat_inc4(r_word_cnt);
          end
          if (wDone) begin
            r_state <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
          if (w_close_words != FRAME_WORDS) begin
            r_frame_err <= 1'b1;
          end
          // Back-to-back runs: the next run's count starts fresh either way.
          r_word_cnt <= '0;
          r_state    <= wDone ? ST_IDLE : ST_BUSY;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_word_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_result_buffer.sv
module tb_w_result_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int FRAME = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clr = 1'b0;
  logic             wr = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             wDone = 1'b1;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             space_ok;
  logic             frame_done;
  logic             frame_err;
  logic             overflow;
  logic [7:0]       frame_cnt;

  w_result_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FRAME (FRAME)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .wr         (wr),
    .din        (din),
    .wDone      (wDone),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .space_ok   (space_ok),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents of the buffer as a queue plus run-level bookkeeping.
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf = 1'b0;
  bit               m_err = 1'b0;
  bit               m_in_run = 1'b0;
  int               m_frames = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_val("out_data", 32'(out_data), 32'(m_q[0]));
    end
    check_val("space_ok", 32'(space_ok), 32'((DEPTH - m_q.size()) >= FRAME));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("frame_err", 32'(frame_err), 32'(m_err));
    check_val("frame_cnt", 32'(frame_cnt), 32'(m_frames % 256));
  endtask

  // Advance the model with the inputs the DUT is about to sample, then clock.
  task automatic tick();
    bit pop;
    bit push;
    if (!rst_n || clr) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_err    = 1'b0;
      m_frames = 0;
    end else begin
      pop  = (m_q.size() > 0) && out_ready;
      push = 1'b0;
      if (wr) begin
        if (m_q.size() < DEPTH || pop) push = 1'b1;
        else m_ovf = 1'b1;
        if (!m_in_run) m_err = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(din);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_ready(input bit rand_ready);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // One wrapper run of n writes. pattern=1 writes 0x0011*(i+1), else random words.
  task automatic do_run(input int n, input bit rand_gaps, input bit rand_ready, input bit pattern);
    wr = 1'b0;
    wDone = 1'b0;
    set_ready(rand_ready);
    tick();
    m_in_run = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 2 && rand_gaps && $urandom_range(0, 2) == 0; g++) begin
        wr = 1'b0;
        set_ready(rand_ready);
        tick();
      end
      wr  = 1'b1;
      din = pattern ? WIDTH'(16'h0011 * (i + 1)) : WIDTH'($urandom);
      set_ready(rand_ready);
      tick();
    end
    wr = 1'b0;
    wDone = 1'b1;
    set_ready(rand_ready);
    tick();
    m_in_run = 1'b0;
    check_val("frame_done_pulse", 32'(frame_done), 32'd1);
    if (n != FRAME) m_err = 1'b1;
    m_frames++;
    set_ready(rand_ready);
    tick();
    check_val("frame_done_end", 32'(frame_done), 32'd0);
  endtask

  task automatic drain();
    wr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    check_val("drained_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    wr = 1'b0;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_data"}, 32'(out_data), 32'd0);
    check_val({tag, "_space"}, 32'(space_ok), 32'd1);
    check_val({tag, "_done"}, 32'(frame_done), 32'd0);
    check_val({tag, "_err"}, 32'(frame_err), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_val({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_val("no_spurious_done", 32'(frame_done), 32'd0);

    // Nominal run, then in-order drain of the known pattern
    out_ready = 1'b0;
    do_run(4, 1'b0, 1'b0, 1'b1);
    check_val("nominal_cnt", 32'(frame_cnt), 32'd1);
    check_val("nominal_err", 32'(frame_err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_val("nominal_drain", 32'(out_data), 32'(16'h0011 * (k + 1)));
      out_ready = 1'b1;
      tick();
    end
    check_val("nominal_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset asserted mid-run with three words buffered
    wDone = 1'b0;
    tick();
    m_in_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr  = 1'b1;
      din = WIDTH'($urandom);
      tick();
    end
    wr = 1'b0;
    check_val("midrun_space_pre", 32'(space_ok), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrun_rst");
    m_in_run = 1'b0;
    wDone = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check_val("midrun_no_done", 32'(frame_done), 32'd0);
    tick();
    check_val("midrun_no_done2", 32'(frame_done), 32'd0);

    // Fill to DEPTH, then one stray write that must be dropped
    do_clr();
    out_ready = 1'b0;
    do_run(4, 1'b1, 1'b0, 1'b0);
    do_run(4, 1'b1, 1'b0, 1'b0);
    check_val("full_space", 32'(space_ok), 32'd0);
    check_val("full_ovf_before", 32'(overflow), 32'd0);
    wr  = 1'b1;
    din = 16'hBEEF;
    tick();
    wr = 1'b0;
    check_val("full_ovf", 32'(overflow), 32'd1);
    check_val("full_space_after", 32'(space_ok), 32'd0);
    drain();

    // Simultaneous push and pop at full
    do_clr();
    out_ready = 1'b0;
    do_run(4, 1'b0, 1'b0, 1'b0);
    do_run(4, 1'b0, 1'b0, 1'b0);
    wr = 1'b1;
    din = 16'hCAFE;
    out_ready = 1'b1;
    tick();
    wr = 1'b0;
    out_ready = 1'b0;
    check_val("pushpop_ovf", 32'(overflow), 32'd0);
    check_val("pushpop_valid", 32'(out_valid), 32'd1);
    check_val("pushpop_tail", 32'(m_q[DEPTH-1]), 32'h0000CAFE);
    drain();

    // Short run sets sticky frame_err until clr
    do_clr();
    do_run(3, 1'b1, 1'b1, 1'b0);
    check_val("short_err", 32'(frame_err), 32'd1);
    do_run(4, 1'b1, 1'b1, 1'b0);
    check_val("short_err_sticky", 32'(frame_err), 32'd1);
    do_clr();
    check_val("short_err_clr", 32'(frame_err), 32'd0);
    check_val("short_cnt_clr", 32'(frame_cnt), 32'd0);

    // Long random traffic: pointer wrap and frame counter wrap
    for (int r = 0; r < 300; r++) begin
      do_run(4, 1'b1, 1'b1, 1'b0);
    end
    check_val("wrap_cnt", 32'(frame_cnt), 32'd44);
    check_val("wrap_err", 32'(frame_err), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
